ahb_lite_des_master: RTL

AHB-Lite single-transfer bus master that drives the Triple DES slave from the host side. It accepts a job (mode, three keys, one 64-bit block) on a valid/ready request port and programs the slave with five NONSEQ writes. It then waits a fixed processing interval, reads the result back, and returns it with an error flag on a valid/ready response port. It sits between a host/test sequencer and the AHB-Lite interconnect in front of the DES slave.

---
 rtl/ahb_des_pkg.sv | 37 +++
 rtl/ahb_des_wait_timer.sv | 19 +
 rtl/ahb_lite_des_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_des_pkg.sv
// Shared encodings for the AHB-Lite Triple DES master: bus codes, slave register map, FSM states.
package ahb_des_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] OFS_MODE = 32'h0000_0000;
  localparam logic [31:0] OFS_KEY1 = 32'h0000_0400;
  localparam logic [31:0] OFS_KEY2 = 32'h0000_0800;
  localparam logic [31:0] OFS_KEY3 = 32'h0000_0C00;
  localparam logic [31:0] OFS_DATA = 32'h0000_1000;

  localparam logic [2:0] HSIZE_DW      = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'h3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_LAST = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_RD_CAP  = 3'd6;
  localparam logic [2:0] ST_RESP    = 3'd7;

  // Write index 0..4 walks mode, key1, key2, key3, data.
  function automatic logic [31:0] reg_ofs(input logic [2:0] idx);
    case (idx)
      3'd0:    return OFS_MODE;
      3'd1:    return OFS_KEY1;
      3'd2:    return OFS_KEY2;
      3'd3:    return OFS_KEY3;
      default: return OFS_DATA;
    endcase
  endfunction

endpackage

// File: rtl/ahb_des_wait_timer.sv
// 8-bit load/enable down-counter; saturates at zero and flags done there.
module ahb_des_wait_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_load_val,
  output logic       o_done
);
  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_cnt <= 8'd0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_en && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end

  assign o_done = (r_cnt == 8'd0);
endmodule

// File: rtl/ahb_lite_des_master.sv
// AHB-Lite master that programs the Triple DES slave and reads the result back.
// Optional AHB_DES_KEY_CACHE_EN skips mode/key writes when they match the last good job.
module ahb_lite_des_master
  import ahb_des_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 48
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [63:0] req_key1,
  input  logic [63:0] req_key2,
  input  logic [63:0] req_key3,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [63:0] HWDATA,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic        r_dph;
  logic        r_mode;
  logic [63:0] r_key1, r_key2, r_key3, r_data;
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [63:0] r_hwdata;
  logic        r_resp_valid, r_resp_err;
  logic [63:0] r_resp_data;

  logic        w_hit, w_err, w_done, w_tmr_load, w_tmr_en;
  logic [2:0]  w_start;
  logic [63:0] w_wdata;

  always_comb begin
    case (r_idx)
      3'd0:    w_wdata = {63'b0, r_mode};
      3'd1:    w_wdata = r_key1;
      3'd2:    w_wdata = r_key2;
      3'd3:    w_wdata = r_key3;
      default: w_wdata = r_data;
    endcase
  end

  // r_dph marks a write data phase overlapping the current WR address phase.
  assign w_err = HREADY && HRESP &&
                 ((r_state == ST_WR && r_dph) || r_state == ST_WR_LAST || r_state == ST_RD_DATA);
  assign w_start    = w_hit ? 3'd4 : 3'd0;
  assign w_tmr_load = (r_state == ST_WR_LAST) && HREADY && !HRESP;
  assign w_tmr_en   = (r_state == ST_WAIT) && HREADY;

  ahb_des_wait_timer u_wait (
    .i_clk      (HCLK),
    .i_rst      (HRESET),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (WAIT_LOAD),
    .o_done     (w_done)
  );

`ifdef AHB_DES_KEY_CACHE_EN
  logic        r_c_vld, r_c_mode;
  logic [63:0] r_c_key1, r_c_key2, r_c_key3;

  assign w_hit = r_c_vld && (r_c_mode == req_mode) && (r_c_key1 == req_key1) &&
                 (r_c_key2 == req_key2) && (r_c_key3 == req_key3);

  always_ff @(posedge HCLK) begin
    if (HRESET || w_err) begin
      r_c_vld <= 1'b0;
    end else if (r_state == ST_RD_CAP) begin
      r_c_vld  <= 1'b1;
      r_c_mode <= r_mode;
      r_c_key1 <= r_key1;
      r_c_key2 <= r_key2;
      r_c_key3 <= r_key3;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_dph        <= 1'b0;
      r_mode       <= 1'b0;
      r_key1       <= '0;
      r_key2       <= '0;
      r_key3       <= '0;
      r_data       <= '0;
      r_haddr      <= '0;
      r_htrans     <= HTRANS_IDLE;
      r_hwrite     <= 1'b0;
      r_hwdata     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else if (w_err) begin
      // Drop whatever is left of the job and report the failure.
      r_state      <= ST_RESP;
      r_dph        <= 1'b0;
      r_htrans     <= HTRANS_IDLE;
      r_resp_valid <= 1'b1;
      r_resp_err   <= 1'b1;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_mode   <= req_mode;
          r_key1   <= req_key1;
          r_key2   <= req_key2;
          r_key3   <= req_key3;
          r_data   <= req_data;
          r_idx    <= w_start;
          r_dph    <= 1'b0;
          r_haddr  <= BASE_ADDR + reg_ofs(w_start);
          r_htrans <= HTRANS_NONSEQ;
          r_hwrite <= 1'b1;
          r_state  <= ST_WR;
        end
        ST_WR: if (HREADY) begin
          r_hwdata <= w_wdata;
          r_dph    <= 1'b1;
          if (r_idx == 3'd4) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_WR_LAST;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_haddr <= BASE_ADDR + reg_ofs(r_idx + 3'd1);
          end
        end
        ST_WR_LAST: if (HREADY) begin
          r_dph   <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (HREADY && w_done) begin
          r_haddr  <= BASE_ADDR + OFS_DATA;
          r_htrans <= HTRANS_NONSEQ;
          r_hwrite <= 1'b0;
          r_state  <= ST_RD_ADDR;
        end
        ST_RD_ADDR: if (HREADY) begin
          r_htrans <= HTRANS_IDLE;
          r_state  <= ST_RD_DATA;
        end
        ST_RD_DATA: if (HREADY) r_state <= ST_RD_CAP;
        // Slave registers its read data, so it is valid one cycle after the data phase.
        ST_RD_CAP: begin
          r_resp_data  <= HRDATA;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign HADDR      = r_haddr;
  assign HTRANS     = r_htrans;
  assign HWRITE     = r_hwrite;
  assign HWDATA     = r_hwdata;
  assign HSIZE      = HSIZE_DW;
  assign HBURST     = HBURST_SINGLE;
  assign HPROT      = HPROT_DATA;
  assign HMASTLOCK  = 1'b0;
endmodule
